// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Byte-stream loader that packs big-endian 32-bit words and
//               writes them into the word-indexed instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_data,
    output logic                 mem_write,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int          c_IDX_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] c_LIMIT = 32'(DEPTH - BASE_ADDR);
    localparam logic [31:0] c_BASE  = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_byte_idx;
    logic [c_IDX_W-1:0]   r_word_idx;
    logic [CNT_WIDTH-1:0] r_count;
    logic [23:0]          r_shift;

    logic w_reject;
    logic w_last;

    // A count that would run past the end of memory is refused up front, so the
    // address arithmetic below never needs a bound check of its own.
    assign w_reject = (word_count == '0) || (32'(word_count) > c_LIMIT);
    assign w_last   = (32'(r_word_idx) == (32'(r_count) - 32'd1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_byte_idx  <= 2'd0;
            r_word_idx  <= '0;
            r_count     <= '0;
            r_shift     <= 24'd0;
            byte_ready  <= 1'b0;
            mem_address <= 32'd0;
            mem_data    <= 32'd0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            r_count    <= word_count;
                            r_byte_idx <= 2'd0;
                            r_word_idx <= '0;
                            r_shift    <= 24'd0;
                            done       <= 1'b0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            r_state    <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        r_shift    <= {r_shift[15:0], byte_in};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // The fourth byte completes the word and goes straight to the write port.
                        if (r_byte_idx == 2'd3) begin
                            mem_write   <= 1'b1;
                            mem_address <= c_BASE + 32'(r_word_idx);
                            mem_data    <= {r_shift, byte_in};
                            byte_ready  <= 1'b0;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_word_idx <= r_word_idx + c_IDX_W'(1);
                        byte_ready <= 1'b1;
                        r_state    <= S_RECV;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Directed and randomized load sequences against a word-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int DEPTH     = 32;
    localparam int BASE_ADDR = 0;
    localparam int CNT_WIDTH = 16;

    logic                 clock      = 1'b0;
    logic                 reset      = 1'b0;
    logic                 start      = 1'b0;
    logic [CNT_WIDTH-1:0] word_count = '0;
    logic [7:0]           byte_in    = 8'd0;
    logic                 byte_valid = 1'b0;
    logic                 byte_ready;
    logic [31:0]          mem_address;
    logic [31:0]          mem_data;
    logic                 mem_write;
    logic                 busy;
    logic                 done;
    logic                 error;

    instr_mem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .word_count  (word_count),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Write log captured mid-cycle, plus a handshake invariant counter.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          ready_viol = 0;
    always @(negedge clock) begin
        if (mem_write) begin
            wa_q.push_back(mem_address);
            wd_q.push_back(mem_data);
            wc_q.push_back(cyc);
        end
        if (reset && busy && !mem_write && !byte_ready) ready_viol++;
        if (mem_write && byte_ready) ready_viol++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        word_count = CNT_WIDTH'(n);
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   budget;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        budget     = 0;
        do begin
            rdy = byte_ready;
            tick();
            budget++;
        end while (!rdy && budget < 50);
        byte_valid = 1'b0;
        if (!rdy) chk("xfer_timeout", rdy, 1);
    endtask

    // gap < 0 selects a random stall of 0..3 cycles per byte
    task automatic send_stream(input logic [7:0] bytes[$], input int first, input int gap);
        for (int i = first; i < bytes.size(); i++)
            send_byte(bytes[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    endtask

    task automatic wait_done(output int when);
        int k;
        k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        when = cyc;
        if (!done) chk("done_timeout", done, 1);
    endtask

    // Reference: word i is bytes 4i..4i+3, most significant first, at BASE_ADDR+i.
    function automatic logic [31:0] word_of(input logic [7:0] bytes[$], input int i);
        return 32'(bytes[4*i]) * 32'h0100_0000 + 32'(bytes[4*i+1]) * 32'h0001_0000
             + 32'(bytes[4*i+2]) * 32'h0000_0100 + 32'(bytes[4*i+3]);
    endfunction

    task automatic check_writes(input string tag, input logic [7:0] bytes[$], input int n);
        chk({tag, "_nwrites"}, wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk({tag, "_addr"}, wa_q[i], BASE_ADDR + i);
            chk({tag, "_data"}, wd_q[i], word_of(bytes, i));
        end
    endtask

    task automatic rand_bytes(output logic [7:0] q[$], input int nwords);
        q.delete();
        for (int i = 0; i < 4 * nwords; i++) q.push_back(8'($urandom));
    endtask

    logic [7:0] bq[$];
    int         t_done;
    int         nw;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_outputs", {byte_ready, mem_write, busy, done, error, mem_address, mem_data}, '0);
        reset = 1'b1;
        tick();

        // Two-word load, stream never stalls
        clear_log();
        bq = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
        do_start(2);
        chk("start_busy", {busy, byte_ready, done, error}, 4'b1100);
        send_stream(bq, 0, 0);
        wait_done(t_done);
        check_writes("two_words", bq, 2);
        if (wc_q.size() == 2) begin
            chk("write_spacing", wc_q[1] - wc_q[0], 5);
            chk("done_latency", t_done - wc_q[1], 1);
        end
        chk("two_words_flags", {done, busy, error}, 3'b100);

        // Same load with 3-cycle stalls; no write may appear before byte 4
        clear_log();
        do_start(2);
        for (int i = 0; i < 3; i++) send_byte(bq[i], 3);
        repeat (3) tick();
        chk("early_write", wa_q.size(), 0);
        chk("ready_in_stall", byte_ready, 1);
        send_stream(bq, 3, 3);
        wait_done(t_done);
        check_writes("stalled", bq, 2);

        // Rejected starts
        clear_log();
        do_start(0);
        chk("reject0_flags", {done, error, busy, byte_ready}, 4'b1100);
        repeat (2) tick();
        do_start(DEPTH - BASE_ADDR + 1);
        chk("reject33_flags", {done, error, busy, byte_ready}, 4'b1100);
        repeat (2) tick();
        chk("reject_no_write", wa_q.size(), 0);
        do_start(1);
        chk("accept_clears", {done, error, busy}, 3'b001);
        rand_bytes(bq, 1);
        send_stream(bq, 0, 0);
        wait_done(t_done);
        check_writes("after_reject", bq, 1);
        chk("after_reject_err", error, 0);

        // Full depth, incrementing byte pattern
        clear_log();
        bq.delete();
        nw = $urandom_range(0, 255);
        for (int i = 0; i < 4 * (DEPTH - BASE_ADDR); i++) bq.push_back(8'(nw + i));
        do_start(DEPTH - BASE_ADDR);
        send_stream(bq, 0, 0);
        wait_done(t_done);
        check_writes("full_depth", bq, DEPTH - BASE_ADDR);
        if (wa_q.size() > 0) chk("last_addr", wa_q[$], BASE_ADDR + DEPTH - 1);

        // Reset after one word and two bytes of the next
        clear_log();
        rand_bytes(bq, 2);
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(bq[i], 0);
        reset = 1'b0;
        tick();
        chk("midload_reset", {byte_ready, mem_write, busy, done, error, mem_address, mem_data}, '0);
        reset = 1'b1;
        tick();
        clear_log();
        rand_bytes(bq, 1);
        do_start(1);
        send_stream(bq, 0, $urandom_range(0, 2));
        wait_done(t_done);
        check_writes("post_reset", bq, 1);

        // start pulse during RECV must not reload the count
        clear_log();
        rand_bytes(bq, 2);
        do_start(2);
        send_byte(bq[0], 0);
        start      = 1'b1;
        word_count = CNT_WIDTH'(5);
        tick();
        start      = 1'b0;
        send_stream(bq, 1, 0);
        wait_done(t_done);
        repeat (12) tick();
        check_writes("start_ignored", bq, 2);
        chk("start_ignored_flags", {done, busy, error}, 3'b100);

        // Randomized loads with random stalls
        for (int r = 0; r < 6; r++) begin
            clear_log();
            nw = $urandom_range(1, 5);
            rand_bytes(bq, nw);
            do_start(nw);
            send_stream(bq, 0, -1);
            wait_done(t_done);
            check_writes("random", bq, nw);
        end

        chk("ready_invariant", ready_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side companion to the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one single-cycle write per word into the word-indexed instruction memory starting at BASE_ADDR. It is used at bring-up and in test benches to program the IF stage's memory before the core is released.

Parameters:
DEPTH, 32, number of 32-bit words in the target instruction memory
BASE_ADDR, 0, word index of the first word written
CNT_WIDTH, 16, width of the word_count input

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
start  input  1  begin a load; sampled only in IDLE or DONE
word_count  input  CNT_WIDTH  number of words to load; latched on accepted start
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_address  output  32  word index to instruction memory
mem_data  output  32  instruction word to write
mem_write  output  1  one-cycle write strobe
busy  output  1  load in progress (RECV or WRITE)
done  output  1  load finished; held until next start or reset
error  output  1  last start rejected (count 0 or > DEPTH - BASE_ADDR); held with done

Behaviour:
- Reset (reset=0 at posedge): state IDLE; byte_ready, mem_write, busy, done, error = 0; mem_address = 0; mem_data = 0; byte index and word index = 0. Reset mid-load abandons the load; words already written stay in memory.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + start=1:
  - If word_count == 0 or word_count > DEPTH - BASE_ADDR: go to DONE with done=1 and error=1 on the next cycle; no writes.
  - Otherwise latch count, clear done and error, reset byte index and word index to 0, go to RECV.
- start is ignored in RECV and WRITE.
- RECV: byte_ready=1, busy=1. A byte transfers when byte_valid && byte_ready at posedge.
  - The assembly register shifts left 8 and inserts byte_in in the LSBs, so the first byte of a word ends up in bits 31:24.
  - On the 4th transfer (byte index 3), go to WRITE; byte index wraps to 0.
  - byte_valid=0 stalls indefinitely; there is no timeout.
- WRITE (exactly 1 cycle): byte_ready=0, mem_write=1, mem_address = BASE_ADDR + word index, mem_data = assembled word.
  - If word index == count-1, the next state is DONE and done=1 on the following cycle.
  - Otherwise increment word index and return to RECV.
- Throughput: at most one word per 5 cycles (4 byte cycles + 1 write cycle).
- mem_address and mem_data are registered and hold their last values outside WRITE. mem_write is high only in WRITE.
- DONE: busy=0, byte_ready=0, done=1. error keeps the value set by the last start.
- The address never exceeds BASE_ADDR + DEPTH - 1, guaranteed by the start check. Word index width is ceil(log2(DEPTH)) + 1.

Test Plan:
- Load 2 words (DEPTH=32, BASE_ADDR=0): start with word_count=2; send bytes 0x20,0x01,0x00,0x05 then 0x8C,0x02,0x00,0x04 with byte_valid held high.
  - mem_write pulses twice, 5 cycles apart: (addr 0, 0x20010005) then (addr 1, 0x8C020004).
  - done=1 and busy=0 one cycle after the second write; error=0.
- Stalled stream: same load with byte_valid deasserted 3 cycles between each byte.
  - Identical writes and data; byte_ready stays 1 throughout RECV; no write occurs before the 4th byte.
- Rejected start: word_count=0 and, separately, word_count=33.
  - Next cycle: done=1, error=1, no mem_write pulse; a subsequent valid start clears both.
- Full depth with BASE_ADDR=0: word_count=32, incrementing data pattern.
  - 32 writes at addresses 0..31; last address is 31; no write at 32.
- Reset mid-load: assert reset=0 after 1 word plus 2 bytes of the second word.
  - All outputs 0 and state IDLE next cycle.
  - A new start with count=1 writes its word at address 0 with the 4 new bytes only, without the stale partial bytes.
- Start while busy: pulse start during RECV with word_count=5.
  - Ignored: the original count completes and done asserts after the original number of writes.
